// File: rtl/ifu.sv
// Instruction fetch unit: byte-serial fetch of an opcode plus 0-3 operands,
// then microcode step sequencing until the decoder flags the last step.
// Optional build macro: IFU_OPERAND_CLEAR_EN clears d1-d3 when a new opcode
// lands, so operand slots beyond the instruction's length read zero.
module ifu #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    input  logic [1:0]  len,
    input  logic        last,
    input  logic        jmp,
    input  logic [15:0] jmp_addr,
    output logic [7:0]  insn,
    output logic [7:0]  d1,
    output logic [7:0]  d2,
    output logic [7:0]  d3,
    output logic [2:0]  is,
    output logic        iv,
    output logic [15:0] pc
);

    typedef enum logic [1:0] {FETCH_OP, DECODE, FETCH_D, EXEC} state_t;

    state_t          state_q, state_d;
    logic [15:0]     pc_q, pc_d;
    logic [15:0]     addr_q, addr_d;
    logic [7:0]      insn_q, insn_d;
    logic [2:0][7:0] opd_q, opd_d;
    logic [2:0]      is_q, is_d;
    logic [1:0]      k_q, k_d;
    logic [1:0]      n_q, n_d;
    logic            req_q, req_d;
    logic            iv_q, iv_d;

    logic            hs;
    logic            exec_end;
    logic [15:0]     pc_next;

    // A byte only completes while our own request is up; stray acks are ignored.
    assign hs       = req_q && mem_ack;
    assign exec_end = last || (is_q == 3'd7);
    assign pc_next  = pc_q + 16'd1 + {14'd0, n_q};

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        insn_d  = insn_q;
        opd_d   = opd_q;
        is_d    = is_q;
        k_d     = k_q;
        n_d     = n_q;
        case (state_q)
            FETCH_OP: begin
                addr_d = pc_q;
                if (hs) begin
                    insn_d  = mem_data;
                    k_d     = 2'd0;
`ifdef IFU_OPERAND_CLEAR_EN
                    opd_d   = '0;
`endif
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // len is only trusted at the end of this cycle
                n_d     = len;
                addr_d  = pc_q + 16'd1;
                state_d = (len == 2'd0) ? EXEC : FETCH_D;
            end
            FETCH_D: begin
                if (hs) begin
                    for (int i = 0; i < 3; i++) begin
                        if (k_q == 2'(i)) opd_d[i] = mem_data;
                    end
                    k_d    = k_q + 2'd1;
                    addr_d = pc_q + 16'd2 + {14'd0, k_q};
                    if ((k_q + 2'd1) == n_q) state_d = EXEC;
                end
            end
            EXEC: begin
                if (exec_end) begin
                    is_d    = 3'd0;
                    pc_d    = jmp ? jmp_addr : pc_next;
                    addr_d  = pc_d;
                    state_d = FETCH_OP;
                end else begin
                    is_d = is_q + 3'd1;
                end
            end
            default: state_d = FETCH_OP;
        endcase
        // Request and valid follow the state being entered so both are registered.
        req_d = (state_d == FETCH_OP) || (state_d == FETCH_D);
        iv_d  = (state_d == EXEC);
    end

    // State register with synchronous reset; reset drops any pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_OP;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            insn_q  <= 8'h00;
            opd_q   <= '0;
            is_q    <= 3'd0;
            k_q     <= 2'd0;
            n_q     <= 2'd0;
            req_q   <= 1'b0;
            iv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            insn_q  <= insn_d;
            opd_q   <= opd_d;
            is_q    <= is_d;
            k_q     <= k_d;
            n_q     <= n_d;
            req_q   <= req_d;
            iv_q    <= iv_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_req  = req_q;
    assign insn     = insn_q;
    assign d1       = opd_q[0];
    assign d2       = opd_q[1];
    assign d3       = opd_q[2];
    assign is       = is_q;
    assign iv       = iv_q;
    assign pc       = pc_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a per-cycle vector table for the basic zero-wait
// instruction, then hand sequences for wait states, forced step end, jumps,
// address wrap (second instance with RESET_PC=FFFE) and reset mid-request.
module tb_ifu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst = 1'b1;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic [1:0]  len = 2'd0;
    logic        last = 1'b0;
    logic        jmp = 1'b0;
    logic [15:0] jmp_addr = 16'h0000;
    logic [7:0]  insn, d1, d2, d3;
    logic [2:0]  is;
    logic        iv;
    logic [15:0] pc;

    // wrap-around instance
    logic        rst_b = 1'b1;
    logic [15:0] mem_addr_b;
    logic        mem_req_b;
    logic        mem_ack_b = 1'b0;
    logic [7:0]  mem_data_b = 8'h00;
    logic [1:0]  len_b = 2'd0;
    logic        last_b = 1'b0;
    logic [7:0]  insn_b, d1_b, d2_b, d3_b;
    logic [2:0]  is_b;
    logic        iv_b;
    logic [15:0] pc_b;

    ifu #(.RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_data(mem_data), .len(len), .last(last),
        .jmp(jmp), .jmp_addr(jmp_addr), .insn(insn), .d1(d1), .d2(d2),
        .d3(d3), .is(is), .iv(iv), .pc(pc)
    );

    ifu #(.RESET_PC(16'hFFFE)) u_dut_b (
        .clk(clk), .rst(rst_b), .mem_addr(mem_addr_b), .mem_req(mem_req_b),
        .mem_ack(mem_ack_b), .mem_data(mem_data_b), .len(len_b), .last(last_b),
        .jmp(1'b0), .jmp_addr(16'h0000), .insn(insn_b), .d1(d1_b), .d2(d2_b),
        .d3(d3_b), .is(is_b), .iv(iv_b), .pc(pc_b)
    );

    logic [7:0] mem [0:65535];
    logic [1:0] lentab [0:255];
    bit         wait_mode = 1'b0;
    bit         wcnt = 1'b0;
    bit         last_en = 1'b0;
    logic [2:0] last_at = 3'd0;
    bit         jmp_en = 1'b0;
    logic [2:0] jmp_at = 3'd0;
    logic [15:0] jmp_tgt = 16'h0000;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // memory and decoder models, evaluated once per cycle from registered outputs
    task automatic drive();
        mem_data = mem[mem_addr];
        if (!wait_mode) begin
            mem_ack = 1'b1;
        end else if (mem_req) begin
            mem_ack = wcnt;
            wcnt    = ~wcnt;
        end else begin
            mem_ack = 1'b0;
            wcnt    = 1'b0;
        end
        len      = lentab[insn];
        last     = last_en && iv && (is == last_at);
        jmp      = jmp_en && iv && (is == jmp_at);
        jmp_addr = jmp_tgt;
        mem_data_b = mem[mem_addr_b];
        mem_ack_b  = 1'b1;
        len_b      = lentab[insn_b];
        last_b     = iv_b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    typedef struct packed {
        logic        rst;
        logic        req;
        logic [15:0] addr;
        logic        iv;
        logic [2:0]  is;
        logic [7:0]  insn;
        logic [15:0] pc;
    } vec_t;

    vec_t tab [0:7];

    initial begin
        int ncyc, first, c;
        bit seq_bad;
        logic [47:0] addrs;

        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        for (int a = 0; a < 256; a++) lentab[a] = 2'd0;
        lentab[8'h20] = 2'd2;
        lentab[8'h30] = 2'd3;

        // ---- zero-wait, len 0, last at is=2 : per-cycle table ----
        mem[16'h0000] = 8'h10;
        mem[16'h0001] = 8'h10;
        last_en = 1'b1; last_at = 3'd2;
        //           rst   req   addr      iv    is    insn   pc
        tab[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 8'h00, 16'h0000};
        tab[1] = '{1'b0, 1'b1, 16'h0000, 1'b0, 3'd0, 8'h00, 16'h0000};
        tab[2] = '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 8'h10, 16'h0000};
        tab[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd0, 8'h10, 16'h0000};
        tab[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd1, 8'h10, 16'h0000};
        tab[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd2, 8'h10, 16'h0000};
        tab[6] = '{1'b0, 1'b1, 16'h0001, 1'b0, 3'd0, 8'h10, 16'h0001};
        tab[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 8'h10, 16'h0001};
        for (int i = 0; i < 8; i++) begin
            rst = tab[i].rst;
            step();
            chk($sformatf("vec%0d req/iv/is/insn/pc/d", i),
                {mem_req, iv, is, insn, pc, d1, d2, d3},
                {tab[i].req, tab[i].iv, tab[i].is, tab[i].insn, tab[i].pc, 24'h000000});
            if (tab[i].req) chk($sformatf("vec%0d mem_addr", i), mem_addr, tab[i].addr);
        end

        // ---- one wait cycle per byte, len 3 at 0004 ----
        mem[16'h0001] = 8'h20; mem[16'h0002] = 8'h01; mem[16'h0003] = 8'h02;
        mem[16'h0004] = 8'h30; mem[16'h0005] = 8'hAA; mem[16'h0006] = 8'hBB;
        mem[16'h0007] = 8'hCC; mem[16'h0008] = 8'h40;
        wait_mode = 1'b1; wcnt = 1'b0; last_at = 3'd0;
        rst = 1'b1; step(); rst = 1'b0;
        for (c = 0; c < 100; c++) begin
            step();
            if (iv && pc == 16'h0004) break;
        end
        chk("wait exec at 0004", {iv, pc}, {1'b1, 16'h0004});
        chk("wait insn", insn, 8'h30);
        chk("wait d1..d3", {d1, d2, d3}, 24'hAABBCC);
        for (c = 0; c < 20; c++) begin
            step();
            if (mem_req && !iv) break;
        end
        chk("wait next pc", pc, 16'h0008);
        chk("wait next addr", {mem_req, mem_addr}, {1'b1, 16'h0008});

        // ---- reset while a request waits for ack, with a same-cycle ack ----
        rst = 1'b1; mem_ack = 1'b1; mem_data = 8'h55;
        step();
        chk("rst req dropped", mem_req, 1'b0);
        chk("rst outputs", {iv, is, insn, pc, mem_addr}, {1'b0, 3'd0, 8'h00, 16'h0000, 16'h0000});
        chk("rst operands", {d1, d2, d3}, 24'h000000);
        rst = 1'b0;
        step();
        chk("post rst req", {mem_req, mem_addr, insn}, {1'b1, 16'h0000, 8'h00});

        // ---- last never asserted: forced end after is=7 ----
        wait_mode = 1'b0; last_en = 1'b0;
        mem[16'h0000] = 8'h10; mem[16'h0001] = 8'h10;
        rst = 1'b1; step(); rst = 1'b0;
        for (c = 0; c < 10; c++) begin
            step();
            if (iv) break;
        end
        ncyc = 0; seq_bad = 1'b0;
        for (c = 0; c < 20 && iv; c++) begin
            if (is !== 3'(c)) seq_bad = 1'b1;
            ncyc++;
            step();
        end
        chk("force exec cycles", ncyc, 8);
        chk("force is sequence", seq_bad, 1'b0);
        chk("force next fetch", {mem_req, is, mem_addr}, {1'b1, 3'd0, 16'h0001});

        // ---- jump on final step, then a mid-EXEC pulse that must not take ----
        last_en = 1'b1; last_at = 3'd2;
        jmp_en = 1'b1; jmp_at = 3'd2; jmp_tgt = 16'h1234;
        mem[16'h1234] = 8'h10;
        rst = 1'b1; step(); rst = 1'b0;
        for (c = 0; c < 10 && !iv; c++) step();
        for (c = 0; c < 20 && iv; c++) step();
        chk("jmp taken", {mem_req, mem_addr, pc}, {1'b1, 16'h1234, 16'h1234});
        jmp_at = 3'd1; jmp_tgt = 16'h5555;
        for (c = 0; c < 10 && !iv; c++) step();
        for (c = 0; c < 20 && iv; c++) step();
        chk("jmp mid ignored", {mem_req, mem_addr, pc}, {1'b1, 16'h1235, 16'h1235});
        jmp_en = 1'b0;

        // ---- RESET_PC=FFFE, len 2: wrap of operand fetch and pc ----
        rst = 1'b1;
        mem[16'hFFFE] = 8'h20; mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
        rst_b = 1'b1; step(); rst_b = 1'b0;
        first = -1; addrs = '0;
        for (c = 1; c < 20; c++) begin
            step();
            if (mem_req_b) begin
                if (first < 0) first = c;
                addrs = {addrs[31:0], mem_addr_b};
            end
            if (iv_b) break;
        end
        chk("wrap latency", c - first, 4);
        chk("wrap fetch addrs", addrs, 48'hFFFE_FFFF_0000);
        chk("wrap operands", {d1_b, d2_b}, 16'h1122);
        step();
        chk("wrap next pc", {mem_req_b, mem_addr_b, pc_b}, {1'b1, 16'h0001, 16'h0001});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: fetches an opcode byte and 0–3 operand bytes over a byte-wide memory handshake and holds them in an instruction register. It sits directly upstream of the decoder block and feeds it `insn`, `d1`–`d3` and the microcode step index `is`. It sequences `is` through execution steps until the decoder signals the last step, then advances the program counter to the next instruction or takes a jump target.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, program counter value after reset.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_addr`  out  16  byte address of the current fetch.
- `mem_req`  out  1  fetch request.
- `mem_ack`  in  1  memory has `mem_data` valid this cycle.
- `mem_data`  in  8  fetched byte.
- `len`  in  2  operand byte count (0–3) for the held `insn`, from decoder.
- `last`  in  1  current `is` is the final microcode step.
- `jmp`  in  1  take `jmp_addr` at end of instruction.
- `jmp_addr`  in  16  jump target.
- `insn`  out  8  opcode byte.
- `d1`, `d2`, `d3`  out  8 each  operand bytes 1–3.
- `is`  out  3  microcode step index.
- `iv`  out  1  instruction valid; high in EXEC only.
- `pc`  out  16  address of the opcode of the held instruction.

## Operation
- States: FETCH_OP, DECODE, FETCH_D, EXEC.
- FETCH_OP:
  - `mem_req`=1, `mem_addr`=`pc`.
  - On `mem_req&&mem_ack`: `insn`<=`mem_data`; operand counter k<=0; go to DECODE.
- DECODE: one cycle with `mem_req`=0, so the decoder resolves `len` from `insn`. `len` is sampled into an internal register n at the end of this cycle, and only then. Next state is EXEC if n=0, else FETCH_D.
- FETCH_D:
  - `mem_req`=1, `mem_addr`=`pc`+1+k.
  - On ack, byte goes to d(k+1); k<=k+1.
  - After the n-th byte, go to EXEC.
- EXEC:
  - `iv`=1, `mem_req`=0.
  - `is` starts at 0 and increments each cycle.
  - The instruction ends on the cycle where `last`=1, or where `is`=7; `is`=7 forces the end.
  - At the end: `pc`<=`jmp`?`jmp_addr`:`pc`+1+n; `is`<=0; go to FETCH_OP.
- Arithmetic: address sums are 16-bit modulo 2^16. 16'hFFFF+1 wraps to 16'h0000 for both operand fetch and `pc` advance.
- `mem_ack` while `mem_req`=0 is ignored.
- `jmp` and `jmp_addr` are sampled only on the final EXEC cycle and ignored otherwise.
- `last` outside EXEC is ignored.
- Reset:
  - `pc`=`RESET_PC`; `insn`,`d1`–`d3`=8'h00; `is`=0; `iv`=0; `mem_req`=0; `mem_addr`=`RESET_PC`.
  - State=FETCH_OP; the first request issues the cycle after `rst` deasserts.
  - Reset during an outstanding request drops it; a same-cycle `mem_ack` is ignored.

## Timing
- All outputs are registered.
- `mem_req` and `mem_addr` are stable until ack. A byte completes in the cycle with `mem_req&&mem_ack`. `mem_req` may stay high into the next byte; `mem_addr` updates on the following edge.
- With zero-wait memory (ack always 1):
  - FETCH_OP is 1 cycle, DECODE is 1 cycle, FETCH_D is n cycles.
  - Instruction latency from the first `mem_req` to `iv`=1 is 2+n cycles.
- EXEC length is min(steps to `last`, 8) cycles. There are no idle cycles between instructions.
- `len` must be valid combinationally, or from a negedge register, by the end of the DECODE cycle.

## Configuration
- `IFU_OPERAND_CLEAR_EN` defined:
  - `d1`–`d3` are cleared to 8'h00 on the FETCH_OP ack edge.
  - Operand slots beyond n read 8'h00 during EXEC.
- Undefined: unfetched operand slots retain the previous instruction's values, which saves the clear logic.

## Test plan
- Reset, zero-wait memory, mem[0]=8'h10, `len`=0, `last` at `is`=2:
  - `iv` rises 2 cycles after the first request.
  - `is` steps 0,1,2.
  - Next fetch at `mem_addr`=16'h0001.
- Opcode at 16'h0004 with `len`=3, bytes AA,BB,CC, one wait cycle per byte:
  - `d1..d3`=AA,BB,CC.
  - Next `pc`=16'h0008.
- `last` never asserted:
  - EXEC ends after `is`=7 (8 cycles).
  - `is` returns to 0 and the next fetch issues.
- `jmp`=1, `jmp_addr`=16'h1234 on the final EXEC cycle: next `mem_addr`=16'h1234. `jmp` pulsed mid-EXEC only has no effect.
- `RESET_PC`=16'hFFFE, `len`=2: operand fetches at FFFF and 0000; next `pc`=16'h0001.
- `rst` while waiting for ack:
  - `mem_req` is 0 the next cycle.
  - All outputs are at reset values.
  - A same-cycle `mem_ack` with data 8'h55 leaves `insn`=8'h00.
